// File: rtl/deshuf3_transpose_if.sv
// Bus interface for deshuf3_transpose: 3-lane input beat stream and
// 3-lane transposed output stream. The master drives beats, the slave
// (the transpose block) drives the output rows.
interface deshuf3_transpose_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_sync;
  logic [W-1:0] a0, a1, a2;
  logic         out_valid;
  logic         out_sync;
  logic [W-1:0] b0, b1, b2;

  modport master (
    output in_valid, in_sync, a0, a1, a2,
    input  out_valid, out_sync, b0, b1, b2
  );

  modport slave (
    input  in_valid, in_sync, a0, a1, a2,
    output out_valid, out_sync, b0, b1, b2
  );
endinterface

// File: rtl/deshuf3_transpose.sv
// deshuf3_transpose: 3x3 block transpose of a 3-lane sample stream.
// Three consecutive valid beats form a block (in_sync marks beat 0); once a
// block is complete, row i is emitted as b_j = in_i[j]. Two ping-pong banks
// let the next block fill while the previous one drains, so gap-free input
// gives a gap-free output. All state updates on the falling clock edge.
// Optional feature: define DESHUF3_BYPASS_EN to add a 'bypass' input which,
// when sampled high at beat 0, passes the block straight through instead.

// One registered output lane; holds its value whenever no row is loaded.
module deshuf3_lane #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Output register: load on a readout cycle, otherwise hold.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

module deshuf3_transpose #(parameter int W = 32) (
  input  logic clk,
  input  logic rst_n,
`ifdef DESHUF3_BYPASS_EN
  input  logic bypass,
`endif
  deshuf3_transpose_if.slave io
);
  typedef enum logic [1:0] {IDLE, R1, R2, R0W} wst_t;

  wst_t st, st_nx;

  logic       wr_en;      // store the current beat this cycle
  logic [1:0] wr_row;     // which row of the write bank it lands in
  logic       blk_done;   // row 2 stored: block complete, hand bank to read
  logic       wr_bank;    // bank being filled
  logic       rd_bank;    // bank being drained
  logic       rd_act;     // readout in progress
  logic [1:0] rd_row;     // row emitted on the next edge while rd_act
  logic       rd_byp;     // drained block is a pass-through block
  logic       out_vld_q;
  logic       out_sync_q;

  // mem[bank][row][lane]; row k holds input beat k.
  logic [1:0][2:0][2:0][W-1:0] mem;
  logic [2:0][W-1:0]           a_pk;
  logic [2:0][W-1:0]           row_d;
  logic [2:0][W-1:0]           row_q;

  assign a_pk = {io.a2, io.a1, io.a0};

  // Write FSM state register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Write FSM next state and beat storage controls. A sync beat always
  // restarts a block at row 0, discarding any partial one; a missing beat
  // mid-block aborts it.
  always_comb begin
    st_nx    = st;
    wr_en    = 1'b0;
    wr_row   = 2'd0;
    blk_done = 1'b0;
    case (st)
      IDLE: begin
        if (io.in_valid && io.in_sync) begin
          wr_en = 1'b1;
          st_nx = R1;
        end
      end
      R1: begin
        if (!io.in_valid) begin
          st_nx = IDLE;
        end else if (io.in_sync) begin
          wr_en = 1'b1;
          st_nx = R1;
        end else begin
          wr_en  = 1'b1;
          wr_row = 2'd1;
          st_nx  = R2;
        end
      end
      R2: begin
        if (!io.in_valid) begin
          st_nx = IDLE;
        end else if (io.in_sync) begin
          wr_en = 1'b1;
          st_nx = R1;
        end else begin
          wr_en    = 1'b1;
          wr_row   = 2'd2;
          blk_done = 1'b1;
          st_nx    = R0W;
        end
      end
      R0W: begin
        // Right after a completed block any valid beat starts the next one,
        // so a stream with sync only on its first beat stays aligned.
        if (io.in_valid) begin
          wr_en = 1'b1;
          st_nx = R1;
        end else begin
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Bank storage; contents need no reset since nothing reads a bank
  // before a full block has been written into it.
  always_ff @(negedge clk) begin
    if (wr_en) mem[wr_bank][wr_row] <= a_pk;
  end

`ifdef DESHUF3_BYPASS_EN
  logic [1:0] byp_bank;

  // Per-bank bypass flag, captured with row 0 of each block.
  always_ff @(negedge clk) begin
    if (wr_en && (wr_row == 2'd0)) byp_bank[wr_bank] <= bypass;
  end

  assign rd_byp = byp_bank[rd_bank];
`else
  assign rd_byp = 1'b0;
`endif

  // Ping-pong bank select: the write bank flips on block completion and the
  // read side takes over the bank that was just filled. Blocks are at least
  // 3 beats apart, so a new completion never lands mid-drain.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_act  <= 1'b0;
      rd_row  <= 2'd0;
    end else if (blk_done) begin
      wr_bank <= ~wr_bank;
      rd_bank <= wr_bank;
      rd_act  <= 1'b1;
      rd_row  <= 2'd0;
    end else if (rd_act) begin
      if (rd_row == 2'd2) begin
        rd_act <= 1'b0;
        rd_row <= 2'd0;
      end else begin
        rd_row <= rd_row + 2'd1;
      end
    end
  end

  // Per-lane row select: transpose reads column rd_row, bypass reads the
  // row straight through.
  for (genvar j = 0; j < 3; j++) begin : g_lane
    assign row_d[j] = rd_byp ? mem[rd_bank][rd_row][j]
                             : mem[rd_bank][j][rd_row];
    deshuf3_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (rd_act),
      .d    (row_d[j]),
      .q    (row_q[j])
    );
  end

  // Output qualifiers, aligned with the lane registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_sync_q <= 1'b0;
    end else begin
      out_vld_q  <= rd_act;
      out_sync_q <= rd_act && (rd_row == 2'd0);
    end
  end

  assign io.out_valid = out_vld_q;
  assign io.out_sync  = out_sync_q;
  assign io.b0        = row_q[0];
  assign io.b1        = row_q[1];
  assign io.b2        = row_q[2];
endmodule

// File: doc/deshuf3_transpose.md
DESHUF3_TRANSPOSE -- requirements
Module: deshuf3_transpose

Interface
REQ-001 Parameter: W, default 32, sample width in bits of every lane.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock; all registers update on the falling edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  lanes a0..a2 carry a beat this cycle.
REQ-006 in_sync  input  1  qualified by in_valid; marks beat 0 of a 3-beat block.
REQ-007 a0, a1, a2  input  W each  parallel input lanes 0..2.
REQ-008 out_valid  output  1  lanes b0..b2 carry a transposed beat.
REQ-009 out_sync  output  1  high with out_valid on row 0 of each output block.
REQ-010 b0, b1, b2  output  W each  parallel output lanes 0..2, registered.

Function
REQ-011 Block: 3 consecutive valid beats k=0,1,2; input element in_i[k] is lane i at beat k.
REQ-012 Output: row i of a block (i=0,1,2) drives b_j = in_i[j] for j=0,1,2, i.e. a 3x3 transpose.
REQ-013 Write FSM states: IDLE, R1, R2, R0W (in R0W the next beat starts a new block).
REQ-014 IDLE: in_valid&in_sync stores row 0 and moves to R1; any other input stays in IDLE.
REQ-015 R1: in_valid stores row 1 and moves to R2; R2: in_valid stores row 2, completes the block, swaps the ping-pong bank, and moves to R0W.
REQ-016 R0W: in_valid (with or without in_sync) stores row 0 of the next block and moves to R1; !in_valid moves to IDLE.
REQ-017 in_valid low in R1 or R2 aborts the block: partial data is discarded, no output is produced for it, and the FSM moves to IDLE.
REQ-018 in_valid&in_sync in R1 or R2 discards the partial block and stores this beat as row 0 of a new block; the FSM moves to R1.
REQ-019 Storage: two 3x3xW banks (ping-pong). Write fills one bank while read drains the other.
REQ-020 Read side: a block completing on edge c outputs rows 0, 1, 2 on the edges c+1, c+2, c+3. out_valid is high for exactly those 3 cycles.
REQ-021 Latency: beat 0 of the input block to row 0 of the output block is exactly 3 clk cycles.
REQ-022 Back-to-back gap-free blocks produce a continuous out_valid stream with no bubble.
REQ-023 An abort or re-sync never corrupts the readout of a block that has already completed.
REQ-024 When out_valid is low, b0..b2 hold their last values and out_sync is 0.
REQ-025 No arithmetic; the datapath is pure reordering and every lane is W bits end to end.

Reset
REQ-026 rst_n low immediately forces the FSM to IDLE, the read counter to idle, and out_valid=0, out_sync=0, b0=b1=b2=0.
REQ-027 Bank contents are don't-care after reset. No output is produced until a full block completes.
REQ-028 Reset asserted mid-block or mid-readout drops all pending data.
REQ-029 Release of rst_n takes effect at the first falling edge after deassertion.

Configuration
REQ-030 Macro DESHUF3_BYPASS_EN: when defined, the block adds port bypass (input, 1 bit), sampled at row 0 of each block.
REQ-031 With bypass=1 for a block, row i outputs b_j = in_j[i] (straight pass-through), with the same 3-cycle latency and the same valid/sync timing.
REQ-032 Without DESHUF3_BYPASS_EN, the bypass port and its logic are absent and the transpose is always performed.

Verification
REQ-033 Reset: rst_n=0 mid-stream -> out_valid=0 and b0..b2=0 immediately; no output until a new in_sync block completes.
REQ-034 Single block: beats (1,2,3),(4,5,6),(7,8,9) with sync on beat 0 -> from cycle 3 on, out rows (1,4,7),(2,5,8),(3,6,9); out_sync high on (1,4,7) only.
REQ-035 Streaming: 4 gap-free blocks, sync on first beat only -> 12 consecutive out_valid cycles, each block transposed, out_sync every 3rd cycle.
REQ-036 Abort: in_valid drops after beat 1 -> no output for that block; the following synced block (10..18) outputs correctly.
REQ-037 Re-sync: in_sync on beat 1 of a block while the previous block is draining -> the drain completes intact and the new block starts from the sync beat.
REQ-038 With DESHUF3_BYPASS_EN and bypass=1: block 1..9 -> rows (1,2,3),(4,5,6),(7,8,9) with latency 3.
